strobe_sequencer: RTL and testbench
===================================

Name: strobe_sequencer

Overview:
- Multi-channel, fully synchronous successor to the gate-delay low-pulse generator. Gate-delay chains are no longer used for strobe timing.
- Each channel converts a rising edge on its trigger into an active-low strobe with a programmable delay and width, counted in clk cycles. A guaranteed high recovery gap follows each strobe.
- Intended consumers are register-file /WE inputs (74HCT670-class parts needing a minimum write pulse width) and RAM /WE timing in the CPU datapath.

Parameters:
- CHANNELS, 4: number of independent strobe channels.
- CNT_W, 4: width of the delay and width counters and config inputs.
- GAP, 1: minimum clk cycles pulse_low[i] stays high after a strobe before a new trigger is accepted (0 allowed).
- RETRIGGER, 0: 1 = a trigger during PULSE reloads the width counter (stretches the strobe); 0 = ignore it and flag overrun.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-channel enable; low aborts that channel and masks its triggers.
- trig  in  CHANNELS  per-channel trigger; the rising edge is the event.
- delay_cfg  in  CNT_W  cycles from the trigger edge to strobe assertion; shared by all channels, sampled at trigger.
- width_cfg  in  CNT_W  strobe width in cycles; shared, sampled at trigger.
- pulse_low  out  CHANNELS  active-low strobe, registered.
- busy  out  CHANNELS  high while a channel is not IDLE, registered.
- overrun  out  CHANNELS  one-cycle high when a trigger edge is dropped, registered.

Behaviour:
- Reset: on any posedge with reset=1, every channel goes to IDLE.
  - pulse_low is all ones; busy and overrun are zero.
  - trig_q is loaded with the current trig, so a trigger held high through reset is not an edge.
- Edge detect: edge[i] = trig[i] & ~trig_q[i] & en[i]. trig_q is registered every cycle.
- Per-channel FSM states and transitions:
  - IDLE:
    - On edge with width_cfg=0: stay IDLE, no strobe, no overrun.
    - On edge with delay_cfg=0: go to PULSE and load wcnt=width_cfg-1.
    - Otherwise: go to DELAY and load dcnt=delay_cfg-1, latching width_cfg.
  - DELAY: decrement dcnt. At dcnt=0, go to PULSE with wcnt=latched width-1.
  - PULSE: pulse_low[i]=0. Decrement wcnt. At wcnt=0:
    - go to RECOVER with gcnt=GAP-1 if GAP>0;
    - otherwise go to IDLE.
  - RECOVER: pulse_low high. Decrement gcnt; at 0, go to IDLE.
- Timing: edge sampled at posedge k gives pulse_low low for exactly W cycles, from posedge k+1+D through posedge k+1+D+W, where D=delay_cfg and W=width_cfg at edge time.
  - Triggers at the clk level are accepted again at the earliest k+1+D+W+GAP.
- Triggers while not IDLE:
  - In DELAY or RECOVER: the edge is dropped and overrun[i] pulses for one cycle, the cycle after the edge.
  - In PULSE with RETRIGGER=0: same as DELAY/RECOVER.
  - In PULSE with RETRIGGER=1: wcnt reloads to width_cfg-1, the strobe stays low continuously, and there is no overrun.
- Abort: en[i]=0 in any non-IDLE state forces IDLE on the next edge.
  - pulse_low[i]=1 and busy[i]=0 from that edge.
  - No RECOVER gap is applied, and no overrun is raised.
- Simultaneous events:
  - reset overrides everything.
  - en low overrides trigger.
  - A trigger coinciding with the last PULSE or RECOVER cycle counts as a non-IDLE trigger (dropped, or reloaded under RETRIGGER=1).
- busy[i] = state != IDLE, registered coincident with the state.
- Config values are sampled only at edge acceptance. Changes mid-sequence have no effect on a running sequence.
- Counters never wrap: the maximum D and W are 2^CNT_W-1.

Decomposition:
- Package strobe_pkg: state encoding constants ST_IDLE, ST_DELAY, ST_PULSE, ST_RECOVER (2-bit).
- Sub-module strobe_channel: one FSM with counters, pulse_low, busy and overrun.
  - strobe_sequencer contains the shared trig_q register and edge logic.
  - It instantiates CHANNELS copies via generate.

Test Plan:
- Reset with trig=4'b0001 held -> no edge after reset release; pulse_low=4'hF, busy=0.
- ch0: delay_cfg=2, width_cfg=3, trig edge sampled at posedge 10 -> pulse_low[0]=0 for posedges 13,14,15, high at 16; busy[0] high posedges 11-16 (GAP=1); no other channel moves.
- delay_cfg=0, width_cfg=0, edge on ch1 -> nothing: busy[1] stays 0, no overrun.
- RETRIGGER=0, W=4: second ch2 edge during PULSE -> overrun[2] high one cycle, strobe still exactly 4 cycles. RETRIGGER=1, same stimulus -> strobe stretched to end 4 cycles after the second edge, no overrun.
- Edge on ch3 sampled at posedge 20, W=5, en[3] dropped so the abort is sampled at posedge 23 -> pulse_low[3] high and busy[3]=0 at 23, no recovery gap; a new edge sampled at 24 is accepted.
- Simultaneous edges on all 4 channels with reset asserted mid-DELAY -> all outputs return to reset values next edge; the next edges are accepted normally.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types for the strobe sequencer: per-channel FSM state encoding.
package strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

endpackage

// File: rtl/strobe_sequencer_if.sv
// Trigger/config/strobe bundle between a controller and the strobe sequencer.
interface strobe_sequencer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4
);
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] trig;
  logic [CNT_W-1:0]    delay_cfg;
  logic [CNT_W-1:0]    width_cfg;
  logic [CHANNELS-1:0] pulse_low;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] overrun;

  modport master (
    output en, trig, delay_cfg, width_cfg,
    input  pulse_low, busy, overrun
  );

  modport slave (
    input  en, trig, delay_cfg, width_cfg,
    output pulse_low, busy, overrun
  );
endinterface

// File: rtl/strobe_channel.sv
// One strobe channel: delay, active-low pulse and recovery gap, all counted in clk cycles.
module strobe_channel
  import strobe_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP       = 1,
  parameter int unsigned RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             trig_edge,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  output logic             pulse_low,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned      GapW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0]  GapLoad = (GAP > 0) ? GapW'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] wlat_q, wlat_d;
  logic [GapW-1:0]  gcnt_q, gcnt_d;
  logic             ovr_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    wlat_d  = wlat_q;
    gcnt_d  = gcnt_q;
    ovr_d   = 1'b0;
    if (!en) begin
      // Abort: straight to idle, no gap, no overrun.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig_edge && width_cfg != '0) begin
            if (delay_cfg == '0) begin
              state_d = ST_PULSE;
              wcnt_d  = width_cfg - CntOne;
            end else begin
              state_d = ST_DELAY;
              dcnt_d  = delay_cfg - CntOne;
              wlat_d  = width_cfg;
            end
          end
        end
        ST_DELAY: begin
          ovr_d = trig_edge;
          if (dcnt_q == '0) begin
            state_d = ST_PULSE;
            wcnt_d  = wlat_q - CntOne;
          end else begin
            dcnt_d = dcnt_q - CntOne;
          end
        end
        ST_PULSE: begin
          if (trig_edge && RETRIGGER != 0 && width_cfg != '0) begin
            wcnt_d = width_cfg - CntOne;
          end else begin
            ovr_d = trig_edge && (RETRIGGER == 0);
            if (wcnt_q == '0) begin
              if (GAP > 0) begin
                state_d = ST_RECOVER;
                gcnt_d  = GapLoad;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              wcnt_d = wcnt_q - CntOne;
            end
          end
        end
        ST_RECOVER: begin
          ovr_d = trig_edge;
          if (gcnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gcnt_d = gcnt_q - GapW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are flopped from next-state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      wlat_q    <= '0;
      gcnt_q    <= '0;
      pulse_low <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      wlat_q    <= wlat_d;
      gcnt_q    <= gcnt_d;
      pulse_low <= (state_d != ST_PULSE);
      busy      <= (state_d != ST_IDLE);
      overrun   <= ovr_d;
    end
  end

endmodule

// File: rtl/strobe_sequencer.sv
// Multi-channel synchronous strobe generator: shared edge detect feeding per-channel FSMs.
module strobe_sequencer
  import strobe_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP       = 1,
  parameter int unsigned RETRIGGER = 0
) (
  input logic               clk,
  input logic               reset,
  strobe_sequencer_if.slave bus
);

  logic [CHANNELS-1:0] trig_q;
  logic [CHANNELS-1:0] edge_q;
  logic [CNT_W-1:0]    dcfg_q;
  logic [CNT_W-1:0]    wcfg_q;

  // Config is captured together with the edge so a channel sees the values at trigger time.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= bus.trig;
      edge_q <= '0;
      dcfg_q <= '0;
      wcfg_q <= '0;
    end else begin
      trig_q <= bus.trig;
      edge_q <= bus.trig & ~trig_q & bus.en;
      dcfg_q <= bus.delay_cfg;
      wcfg_q <= bus.width_cfg;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    strobe_channel #(
      .CNT_W    (CNT_W),
      .GAP      (GAP),
      .RETRIGGER(RETRIGGER)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (bus.en[i]),
      .trig_edge(edge_q[i]),
      .delay_cfg(dcfg_q),
      .width_cfg(wcfg_q),
      .pulse_low(bus.pulse_low[i]),
      .busy     (bus.busy[i]),
      .overrun  (bus.overrun[i])
    );
  end

endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed bench: two sequencers (RETRIGGER 0 and 1) driven alike, checked against a cycle scoreboard.
module tb_strobe_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic [3:0] trig;
  logic [3:0] dcfg;
  logic [3:0] wcfg;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] mask;
    logic [3:0] pl;
    logic [3:0] bs;
    logic [3:0] ov;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [11:0] obs;
  logic [11:0] want;
  logic [11:0] m;

  strobe_sequencer_if #(.CHANNELS(4), .CNT_W(4)) bus0 ();
  strobe_sequencer_if #(.CHANNELS(4), .CNT_W(4)) bus1 ();

  assign bus0.en = en;
  assign bus0.trig = trig;
  assign bus0.delay_cfg = dcfg;
  assign bus0.width_cfg = wcfg;
  assign bus1.en = en;
  assign bus1.trig = trig;
  assign bus1.delay_cfg = dcfg;
  assign bus1.width_cfg = wcfg;

  strobe_sequencer #(.CHANNELS(4), .CNT_W(4), .GAP(1), .RETRIGGER(0)) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  strobe_sequencer #(.CHANNELS(4), .CNT_W(4), .GAP(1), .RETRIGGER(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc = number of posedges seen; outputs are checked at the following negedge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        e    = sb[i];
        obs  = (e.dut == 0) ? {bus0.pulse_low, bus0.busy, bus0.overrun}
                            : {bus1.pulse_low, bus1.busy, bus1.overrun};
        want = {e.pl, e.bs, e.ov};
        m    = {e.mask, e.mask, e.mask};
        tests++;
        assert ((obs & m) === (want & m)) else begin
          fails++;
          $error("FAIL %s cyc=%0d dut=%0d observed{pl,busy,ovr}=%h expected=%h", e.tag, cyc,
                 e.dut, obs & m, want & m);
        end
        sb.delete(i);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic void expect_at(input int c, input int dut, input logic [3:0] mask,
                                    input logic [3:0] pl, input logic [3:0] bs,
                                    input logic [3:0] ov, input string tag);
    exp_t x;
    x.cyc = c; x.dut = dut; x.mask = mask; x.pl = pl; x.bs = bs; x.ov = ov; x.tag = tag;
    sb.push_back(x);
  endfunction

  initial begin
    reset = 1'b1;
    en    = 4'hF;
    trig  = 4'b0001;
    dcfg  = 4'd0;
    wcfg  = 4'd0;

    // Trigger held high through reset must not count as an edge.
    for (int c = 2; c <= 9; c++) begin
      expect_at(c, 0, 4'hF, 4'hF, 4'h0, 4'h0, "reset_idle");
      expect_at(c, 1, 4'hF, 4'hF, 4'h0, 4'h0, "reset_idle_rt");
    end
    at_cyc(3); reset = 1'b0;
    at_cyc(6); trig = 4'b0000;

    // ch0: D=2 W=3, edge sampled at posedge 10.
    at_cyc(9); dcfg = 4'd2; wcfg = 4'd3; trig = 4'b0001;
    for (int c = 10; c <= 18; c++)
      expect_at(c, 0, 4'hF, (c >= 13 && c <= 15) ? 4'b1110 : 4'hF,
                (c >= 11 && c <= 16) ? 4'b0001 : 4'h0, 4'h0, "ch0_d2_w3");
    at_cyc(12); trig = 4'b0000;

    // ch3: D=0 W=5, edge at 20, abort sampled at 23, re-trigger sampled at 24.
    at_cyc(19); dcfg = 4'd0; wcfg = 4'd5; trig = 4'b1000;
    expect_at(20, 0, 4'b1000, 4'hF, 4'h0, 4'h0, "ch3_pre");
    expect_at(21, 0, 4'b1000, 4'b0111, 4'b1000, 4'h0, "ch3_pulse");
    expect_at(22, 0, 4'b1000, 4'b0111, 4'b1000, 4'h0, "ch3_pulse");
    expect_at(23, 0, 4'b1000, 4'hF, 4'h0, 4'h0, "ch3_abort");
    expect_at(24, 0, 4'b1000, 4'hF, 4'h0, 4'h0, "ch3_abort_idle");
    at_cyc(21); trig = 4'b0000;
    at_cyc(22); en = 4'b0111;
    at_cyc(23); en = 4'hF; trig = 4'b1000;
    for (int c = 25; c <= 31; c++)
      expect_at(c, 0, 4'b1000, (c <= 29) ? 4'b0111 : 4'hF, (c <= 30) ? 4'b1000 : 4'h0, 4'h0,
                "ch3_after_abort");
    at_cyc(26); trig = 4'b0000;

    // ch1: D=0 W=0 produces nothing.
    at_cyc(39); dcfg = 4'd0; wcfg = 4'd0; trig = 4'b0010;
    for (int c = 40; c <= 43; c++)
      expect_at(c, 0, 4'b0010, 4'hF, 4'h0, 4'h0, "ch1_w0");
    at_cyc(42); trig = 4'b0000;

    // ch2: W=4, second edge (sampled 52) lands in PULSE.
    at_cyc(49); wcfg = 4'd4; trig = 4'b0100;
    for (int c = 50; c <= 56; c++)
      expect_at(c, 0, 4'b0100, (c >= 51 && c <= 54) ? 4'b1011 : 4'hF,
                (c >= 51 && c <= 55) ? 4'b0100 : 4'h0, (c == 53) ? 4'b0100 : 4'h0,
                "ch2_overrun");
    for (int c = 50; c <= 58; c++)
      expect_at(c, 1, 4'b0100, (c >= 51 && c <= 56) ? 4'b1011 : 4'hF,
                (c >= 51 && c <= 57) ? 4'b0100 : 4'h0, 4'h0, "ch2_retrigger");
    at_cyc(50); trig = 4'b0000;
    at_cyc(51); trig = 4'b0100;
    at_cyc(53); trig = 4'b0000;

    // All channels triggered, reset lands mid-DELAY, then a fresh sequence.
    at_cyc(60); dcfg = 4'd5; wcfg = 4'd2; trig = 4'hF;
    expect_at(61, 0, 4'hF, 4'hF, 4'h0, 4'h0, "all_pre");
    expect_at(62, 0, 4'hF, 4'hF, 4'hF, 4'h0, "all_delay");
    expect_at(63, 0, 4'hF, 4'hF, 4'hF, 4'h0, "all_delay");
    expect_at(64, 0, 4'hF, 4'hF, 4'h0, 4'h0, "all_reset");
    expect_at(64, 1, 4'hF, 4'hF, 4'h0, 4'h0, "all_reset_rt");
    for (int c = 65; c <= 68; c++)
      expect_at(c, 0, 4'hF, 4'hF, 4'h0, 4'h0, "post_reset_idle");
    at_cyc(63); reset = 1'b1;
    at_cyc(64); reset = 1'b0;
    at_cyc(65); trig = 4'h0;
    at_cyc(67); dcfg = 4'd1; wcfg = 4'd1; trig = 4'hF;
    expect_at(69, 0, 4'hF, 4'hF, 4'hF, 4'h0, "all_d1");
    expect_at(70, 0, 4'hF, 4'h0, 4'hF, 4'h0, "all_pulse");
    expect_at(70, 1, 4'hF, 4'h0, 4'hF, 4'h0, "all_pulse_rt");
    expect_at(71, 0, 4'hF, 4'hF, 4'hF, 4'h0, "all_recover");
    expect_at(72, 0, 4'hF, 4'hF, 4'h0, 4'h0, "all_idle");

    at_cyc(76);
    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
